// File: rtl/bf16_pkg.sv
// Shared constants and the loader state type for the bfloat16 divider byte-stream loader.
`timescale 1ns/1ps
package bf16_pkg;

  localparam int BF16_W         = 16;
  localparam int SIGN_BIT       = 15;
  localparam int EXP_MSB        = 14;
  localparam int EXP_LSB        = 7;
  localparam int MAN_MSB        = 6;
  localparam int MAN_LSB        = 0;
  localparam int FRAME_IN_BYTES = 4;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    WAIT    = 2'd1,
    SEND_HI = 2'd2,
    SEND_LO = 2'd3
  } loader_state_e;

endpackage

// File: rtl/bf16_div_stream_loader.sv
// Byte-stream loader around the combinational bf16 divider: 4 bytes in, 2 bytes out.
// Optional inter-byte idle timeout is enabled with the macro BF16_LOADER_TIMEOUT_EN.
`timescale 1ns/1ps
module bf16_div_stream_loader
  import bf16_pkg::*;
#(
  parameter int DIV_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic [BF16_W-1:0] op_a,
  output logic [BF16_W-1:0] op_b,
  input  logic [BF16_W-1:0] div_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              busy,
  output logic [15:0]       frame_count
`ifdef BF16_LOADER_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  if (DIV_LATENCY < 1 || DIV_LATENCY > 15) begin : g_bad_latency
    $error("DIV_LATENCY must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1048575) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 20-bit idle counter");
  end

  localparam logic [1:0] LAST_BYTE = 2'(FRAME_IN_BYTES - 1);
  localparam logic [3:0] WAIT_INIT = 4'(DIV_LATENCY);

  loader_state_e     state, state_n;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic [3:0]        wait_cnt, wait_cnt_n;
  logic [7:0]        sh_a_hi, sh_a_lo, sh_b_hi;
  logic [BF16_W-1:0] result_q;
  logic              accept, load_ops, capture, hi_done, frame_done;
  logic              timeout_hit;

  // in_ready follows the state register; flush masks it for its own cycle.
  assign in_ready = (state == LOAD) && !flush;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != LOAD) || (byte_cnt != 2'd0);

  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    wait_cnt_n = wait_cnt;
    load_ops   = 1'b0;
    capture    = 1'b0;
    hi_done    = 1'b0;
    frame_done = 1'b0;
    case (state)
      LOAD: begin
        if (accept) begin
          byte_cnt_n = byte_cnt + 2'd1;
          if (byte_cnt == LAST_BYTE) begin
            load_ops   = 1'b1;
            byte_cnt_n = 2'd0;
            wait_cnt_n = WAIT_INIT;
            state_n    = WAIT;
          end
        end else if (timeout_hit) begin
          byte_cnt_n = 2'd0;
        end
      end
      WAIT: begin
        wait_cnt_n = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) begin
          capture = 1'b1;
          state_n = SEND_HI;
        end
      end
      SEND_HI: begin
        if (out_ready) begin
          hi_done = 1'b1;
          state_n = SEND_LO;
        end
      end
      SEND_LO: begin
        if (out_ready) begin
          frame_done = 1'b1;
          state_n    = LOAD;
        end
      end
      default: state_n = LOAD;
    endcase
    if (flush) begin
      state_n    = LOAD;
      byte_cnt_n = 2'd0;
      load_ops   = 1'b0;
      capture    = 1'b0;
      hi_done    = 1'b0;
      frame_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      byte_cnt    <= 2'd0;
      wait_cnt    <= 4'd0;
      sh_a_hi     <= 8'd0;
      sh_a_lo     <= 8'd0;
      sh_b_hi     <= 8'd0;
      op_a        <= '0;
      op_b        <= '0;
      result_q    <= '0;
      out_valid   <= 1'b0;
      out_data    <= 8'd0;
      frame_count <= 16'd0;
    end else begin
      state     <= state_n;
      byte_cnt  <= byte_cnt_n;
      wait_cnt  <= wait_cnt_n;
      out_valid <= (state_n == SEND_HI) || (state_n == SEND_LO);
      if (accept) begin
        case (byte_cnt)
          2'd0:    sh_a_hi <= in_data;
          2'd1:    sh_a_lo <= in_data;
          2'd2:    sh_b_hi <= in_data;
          default: ;
        endcase
      end
      // Both operands change together so the divider never sees a mixed pair.
      if (load_ops) begin
        op_a <= {sh_a_hi, sh_a_lo};
        op_b <= {sh_b_hi, in_data};
      end
      if (capture) begin
        result_q <= div_result;
        out_data <= div_result[15:8];
      end
      if (hi_done)    out_data    <= result_q[7:0];
      if (frame_done) frame_count <= frame_count + 16'd1;
    end
  end

`ifdef BF16_LOADER_TIMEOUT_EN
  localparam logic [19:0] IDLE_LAST = 20'(TIMEOUT_CYCLES - 1);
  logic [19:0] idle_cnt;
  logic        idle_run;

  assign idle_run    = (state == LOAD) && (byte_cnt != 2'd0) && !accept && !flush;
  assign timeout_hit = idle_run && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= 20'd0;
      timeout  <= 1'b0;
    end else begin
      timeout <= timeout_hit;
      if (!idle_run || timeout_hit) idle_cnt <= 20'd0;
      else                          idle_cnt <= idle_cnt + 20'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_bf16_div_stream_loader.sv
// Directed bench for bf16_div_stream_loader with a table-driven stand-in for the bf16 divider.
`timescale 1ns/1ps
module tb_bf16_div_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [15:0] op_a, op_b;
  logic [15:0] div_result;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic [15:0] frame_count;
`ifdef BF16_LOADER_TIMEOUT_EN
  logic        timeout;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  bf16_div_stream_loader #(.DIV_LATENCY(1), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .op_a(op_a), .op_b(op_b), .div_result(div_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .frame_count(frame_count)
`ifdef BF16_LOADER_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  // Divider stand-in: hand-computed quotients for the operand pairs used below.
  always_comb begin
    case ({op_a, op_b})
      {16'h40C0, 16'h4040}: div_result = 16'h4000; // 6/3
      {16'h4080, 16'h4000}: div_result = 16'h4000; // 4/2
      {16'h3F80, 16'h4000}: div_result = 16'h3F00; // 1/2
      {16'h40A0, 16'h4000}: div_result = 16'h4020; // 5/2
      {16'h4000, 16'h3F80}: div_result = 16'h4000; // 2/1
      default:              div_result = 16'hDEAD;
    endcase
  end

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk_bit("send_wait_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] f);
    send_byte(f[31:24]);
    send_byte(f[23:16]);
    send_byte(f[15:8]);
    send_byte(f[7:0]);
  endtask

  task automatic recv_byte(input string tag);
    logic [7:0] exp;
    int n = 0;
    exp = exp_q.pop_front();
    @(negedge clk);
    out_ready = 1'b1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_bit({tag, "_valid"}, out_valid, 1'b1);
    chk_word({tag, "_data"}, 16'(out_data), 16'(exp));
    chk_bit({tag, "_in_ready_low"}, in_ready, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int seen_at;
    int pulses;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_bit("rst_in_ready", in_ready, 1'b1);
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_word("rst_frame_count", frame_count, 16'h0000);
    chk_word("rst_op_a", op_a, 16'h0000);
    chk_word("rst_op_b", op_b, 16'h0000);
    chk_word("rst_out_data", 16'(out_data), 16'h0000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Frame 1: 6.0 / 3.0, with exact latency checks.
    send_byte(8'h40); send_byte(8'hC0);
    chk_bit("partial_busy", busy, 1'b1);
    send_byte(8'h40); send_byte(8'h40);
    chk_word("f1_op_a", op_a, 16'h40C0);
    chk_word("f1_op_b", op_b, 16'h4040);
    chk_bit("f1_in_ready_after_last", in_ready, 1'b0);
    chk_bit("f1_out_valid_T", out_valid, 1'b0);
    @(posedge clk); #1;
    chk_bit("f1_out_valid_T+2", out_valid, 1'b1);
    chk_word("f1_first_data", 16'(out_data), 16'h0040);
    exp_q.push_back(8'h40); exp_q.push_back(8'h00);
    recv_byte("f1_hi"); recv_byte("f1_lo");
    chk_word("f1_frame_count", frame_count, 16'd1);
    chk_bit("f1_idle_busy", busy, 1'b0);
    chk_bit("f1_idle_out_valid", out_valid, 1'b0);

    // Back-to-back frames: 4/2 then 1/2.
    send_frame(32'h4080_4000);
    exp_q.push_back(8'h40); exp_q.push_back(8'h00);
    recv_byte("b2b1_hi"); recv_byte("b2b1_lo");
    send_frame(32'h3F80_4000);
    exp_q.push_back(8'h3F); exp_q.push_back(8'h00);
    recv_byte("b2b2_hi"); recv_byte("b2b2_lo");
    chk_word("b2b_frame_count", frame_count, 16'd3);

    // Backpressure during SEND_HI: 5/2.
    send_frame(32'h40A0_4000);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_bit("bp_out_valid", out_valid, 1'b1);
      chk_word("bp_out_data", 16'(out_data), 16'h0040);
    end
    exp_q.push_back(8'h40); exp_q.push_back(8'h20);
    recv_byte("bp_hi"); recv_byte("bp_lo");
    chk_word("bp_frame_count", frame_count, 16'd4);

    // Flush after two bytes, with a byte offered during the flush cycle.
    send_byte(8'h40); send_byte(8'hA0);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    #1;
    chk_bit("flush_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk_bit("flush_busy", busy, 1'b0);
    chk_word("flush_keeps_op_a", op_a, 16'h40A0);
    chk_word("flush_keeps_count", frame_count, 16'd4);
    send_frame(32'h4000_3F80);
    chk_word("post_flush_op_a", op_a, 16'h4000);
    chk_word("post_flush_op_b", op_b, 16'h3F80);
    exp_q.push_back(8'h40); exp_q.push_back(8'h00);
    recv_byte("pf_hi"); recv_byte("pf_lo");
    chk_word("pf_frame_count", frame_count, 16'd5);

    // Reset while SEND_LO is pending.
    send_frame(32'h40C0_4040);
    exp_q.push_back(8'h40);
    recv_byte("rs_hi");
    @(negedge clk);
    chk_bit("rs_in_send_lo", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_bit("rs_out_valid", out_valid, 1'b0);
    chk_word("rs_frame_count", frame_count, 16'd0);
    chk_bit("rs_in_ready", in_ready, 1'b1);
    chk_word("rs_op_a", op_a, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(32'h3F80_4000);
    exp_q.push_back(8'h3F); exp_q.push_back(8'h00);
    recv_byte("ar_hi"); recv_byte("ar_lo");
    chk_word("ar_frame_count", frame_count, 16'd1);

`ifdef BF16_LOADER_TIMEOUT_EN
    // One byte then 50 idle cycles: a single timeout pulse, partial frame discarded.
    send_byte(8'h40);
    seen_at = 0;
    pulses = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (timeout) begin
        pulses++;
        if (seen_at == 0) seen_at = k;
      end
    end
    chk_word("to_pulse_count", 16'(pulses), 16'd1);
    chk_word("to_pulse_cycle", 16'(seen_at), 16'd51);
    chk_bit("to_busy_cleared", busy, 1'b0);
    send_frame(32'h4080_4000);
    exp_q.push_back(8'h40); exp_q.push_back(8'h00);
    recv_byte("to_hi"); recv_byte("to_lo");
    chk_word("to_frame_count", frame_count, 16'd2);
`else
    seen_at = 0;
    pulses = 0;
`endif

    chk_word("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
